// File: rtl/ln_input_pkg.sv
// ln_input_pkg
//   Shared definitions for the layer-0 input deserializer. This package holds the default
//   frame geometry, the default binarization threshold and the deserializer state type.
//   It has no ports.
package ln_input_pkg;

   localparam int unsigned DEF_N_PIX  = 784;     // layer-0 input feature count (28x28)
   localparam int unsigned DEF_PIX_W  = 8;       // grayscale pixel width
   localparam logic [7:0]  DEF_THRESH = 8'd128;  // pixel >= threshold -> 1

   // FILL: accepting pixels; FULL: holding a complete frame for the neuron array
   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

endpackage

// File: rtl/ln_pix_binarize.sv
// ln_pix_binarize
//   Purely combinational pixel binarizer: bin = (pix >= THRESH), unsigned compare.
//   Ports:
//     pix  in  PIX_W  unsigned grayscale pixel
//     bin  out 1      binarized pixel
module ln_pix_binarize
   import ln_input_pkg::*;
#(
   parameter int unsigned      PIX_W  = DEF_PIX_W,
   parameter logic [PIX_W-1:0] THRESH = PIX_W'(DEF_THRESH)
) (
   input  logic [PIX_W-1:0] pix,
   output logic             bin
);

   assign bin = (pix >= THRESH);

endmodule

// File: rtl/ln_input_deserializer.sv
// ln_input_deserializer
//   Collects N_PIX grayscale pixel beats, binarizes each one against THRESH and presents the
//   whole binarized frame as a single N_PIX-bit word to the layer-0 neuron array. Bit k of
//   out_data is pixel k in arrival order. While a frame is held no pixels are accepted, so
//   the minimum frame period is N_PIX+1 cycles.
//
//   Optional framing check (compile-time macro LN_LAST_CHECK_EN):
//     defined   - in_last before the final pixel aborts the frame (err_last pulse, counter
//                 cleared, no out_valid); a missing in_last on the final pixel pulses
//                 err_last but the frame still completes.
//     undefined - in_last is ignored and err_last is tied to 0.
//
//   Ports:
//     clk        in   1      sole clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     in_valid   in   1      pixel beat valid
//     in_ready   out  1      pixel beat accepted when in_valid && in_ready
//     in_data    in   PIX_W  unsigned grayscale pixel
//     in_last    in   1      marks the final pixel of a frame
//     out_valid  out  1      binarized frame available
//     out_ready  in   1      neuron array consumes the frame
//     out_data   out  N_PIX  binarized frame
//     err_last   out  1      one-cycle framing-error pulse
module ln_input_deserializer
   import ln_input_pkg::*;
#(
   parameter int unsigned      N_PIX  = DEF_N_PIX,
   parameter int unsigned      PIX_W  = DEF_PIX_W,
   parameter logic [PIX_W-1:0] THRESH = PIX_W'(DEF_THRESH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_PIX-1:0] out_data,
   output logic             err_last
);

   // Guard keeps the counter at least one bit wide for degenerate single-pixel frames.
   localparam int unsigned      CNT_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
   logic [N_PIX-1:0]   frame_q;
   logic               pix_bit;
   logic               accept;
   logic               at_last;
   logic               early_end;

   // ---------------------------------------------------------------------------------------
   // Pixel comparator
   // ---------------------------------------------------------------------------------------
   ln_pix_binarize #(
      .PIX_W  (PIX_W),
      .THRESH (THRESH)
   ) u_binarize (
      .pix (in_data),
      .bin (pix_bit)
   );

   assign accept  = in_valid && in_ready;
   assign at_last = (pix_cnt_q == LAST_IDX);

   // ---------------------------------------------------------------------------------------
   // Framing check
   // ---------------------------------------------------------------------------------------
`ifdef LN_LAST_CHECK_EN
   logic err_d, err_q;

   always_comb begin
      early_end = accept && in_last && !at_last;
      // Either an early in_last or a missing one on the final pixel is a framing error.
      err_d     = early_end || (accept && at_last && !in_last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_last = err_q;
`else
   logic unused_in_last;

   assign unused_in_last = in_last;
   assign early_end      = 1'b0;
   assign err_last       = 1'b0;
`endif

   // ---------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FILL;
         pix_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // FSM: next state and pixel counter
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               if (early_end) begin
                  // Aborted frame: restart at pixel 0, stale bits get overwritten later.
                  pix_cnt_d = '0;
               end else if (at_last) begin
                  pix_cnt_d = '0;
                  state_d   = FULL;
               end else begin
                  pix_cnt_d = pix_cnt_q + CNT_W'(1);
               end
            end
         end
         FULL: begin
            if (out_ready) begin
               state_d = FILL;
            end
         end
         default: begin
            state_d   = FILL;
            pix_cnt_d = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // FSM: outputs (state only, never in_valid)
   // ---------------------------------------------------------------------------------------
   always_comb begin
      in_ready  = (state_q == FILL);
      out_valid = (state_q == FULL);
   end

   // ---------------------------------------------------------------------------------------
   // Frame register: written one bit per accepted beat, otherwise holds its value
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '0;
      end else if (accept) begin
         frame_q[pix_cnt_q] <= pix_bit;
      end
   end

   assign out_data = frame_q;

endmodule

// File: tb/tb_ln_input_deserializer.sv
// tb_ln_input_deserializer
//   Scoreboard bench: expected frames are queued when a frame is issued, a monitor pops and
//   compares each time the DUT hands a frame over (out_valid && out_ready).
module tb_ln_input_deserializer;
   import ln_input_pkg::*;

   localparam int NP = 784;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [NP-1:0] out_data;
   logic          err_last;

   always #5 clk = ~clk;

   ln_input_deserializer #(
      .N_PIX  (NP),
      .PIX_W  (8),
      .THRESH (8'd128)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err_last  (err_last)
   );

   int            errors = 0;
   int            checks = 0;
   logic [NP-1:0] exp_q[$];
   int            pushed = 0;
   int            popped = 0;
   int            err_cycles = 0;
   int            err_pulses = 0;
   logic          err_prev = 1'b0;
   int            exp_err = 0;
   logic [7:0]    fr[NP];
   logic [NP-1:0] last_exp;

   task automatic check(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: frame handover and err_last pulse accounting
   always @(negedge clk) begin
      if (rst_n) begin
         if (err_last) begin
            err_cycles++;
            if (!err_prev) err_pulses++;
         end
         err_prev = err_last;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got %0h expected none", out_data);
            end else begin
               check("frame", out_data, exp_q.pop_front());
               popped++;
            end
         end
      end else begin
         err_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pix(input logic [7:0] d, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && n < 2000) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         errors++;
         checks++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 2000 cycles");
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $fatal(1, "stimulus stalled");
      end
      tick();
      // Junk on the data lines while idle must be ignored.
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
   endtask

   // Sends fr[0..NP-1]; in_last on index last_at (-1: never). Optionally queues the model.
   task automatic send_frame(input bit idle_rand, input bit push, input int last_at);
      logic [NP-1:0] e;
      for (int k = 0; k < NP; k++) e[k] = (fr[k] >= 8'd128);
      last_exp = e;
      if (push) begin
         exp_q.push_back(e);
         pushed++;
      end
      for (int k = 0; k < NP; k++) begin
         if (idle_rand) begin
            while ($urandom_range(0, 99) < 30) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               in_last  = 1'($urandom);
               tick();
            end
         end
         send_pix(fr[k], (k == last_at));
      end
   endtask

   initial begin
      int            hold_bad;
      int            base;
      logic [NP-1:0] alt;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      check("rst_err_last", err_last, 0);
      rst_n = 1'b1;
      tick();

      // Alternating 200/10: even bits set, handed over in one cycle
      for (int k = 0; k < NP; k++) fr[k] = (k % 2 == 0) ? 8'd200 : 8'd10;
      alt = {196{4'h5}};
      exp_q.push_back(alt);
      pushed++;
      send_frame(1'b0, 1'b0, NP - 1);
      check("alt_out_valid_after_last", out_valid, 1);
      check("alt_out_data", out_data, alt);
      tick();
      check("alt_consumed_out_valid", out_valid, 0);
      check("alt_consumed_in_ready", in_ready, 1);

      // Back-pressure: frame held for 50 cycles
      out_ready = 1'b0;
      for (int k = 0; k < NP; k++) fr[k] = 8'(k);
      send_frame(1'b0, 1'b1, NP - 1);
      hold_bad = 0;
      for (int c = 0; c < 50; c++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== last_exp) hold_bad++;
         tick();
      end
      check("hold_cycles_bad", hold_bad, 0);
      out_ready = 1'b1;
      tick();
      check("release_in_ready", in_ready, 1);
      check("release_out_valid", out_valid, 0);

      // Threshold boundary
      for (int k = 0; k < NP; k++) fr[k] = 8'd0;
      fr[0] = 8'd127;
      fr[1] = 8'd128;
      fr[2] = 8'd255;
      send_frame(1'b0, 1'b1, NP - 1);
      check("thr_127_bit", out_data[0], 0);
      check("thr_128_bit", out_data[1], 1);
      tick();

      // Reset mid-frame after pixel 400
      for (int k = 0; k <= 400; k++) send_pix(8'd255, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_in_ready", in_ready, 1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < NP; k++) fr[k] = 8'd10;
      fr[0] = 8'd200;
      base = pushed;
      send_frame(1'b0, 1'b1, NP - 1);
      check("postrst_bit0_frame", out_data, NP'(1));
      tick();
      check("postrst_one_frame", popped, base + 1);

`ifdef LN_LAST_CHECK_EN
      // Early in_last at pixel 99 aborts the frame
      base = err_pulses;
      for (int k = 0; k < 100; k++) send_pix(8'd255, (k == 99));
      tick();
      tick();
      check("early_last_err_pulse", err_pulses - base, 1);
      check("early_last_no_valid", out_valid, 0);
      exp_err++;
      base = err_pulses;
      for (int k = 0; k < NP; k++) fr[k] = (k % 3 == 0) ? 8'd129 : 8'd5;
      send_frame(1'b0, 1'b1, NP - 1);
      tick();
      tick();
      check("clean_frame_no_err", err_pulses - base, 0);
`endif

      // Missing in_last on the final pixel: the frame still completes
      base = err_pulses;
      for (int k = 0; k < NP; k++) fr[k] = 8'(k * 7);
      send_frame(1'b0, 1'b1, -1);
      tick();
      tick();
`ifdef LN_LAST_CHECK_EN
      check("missing_last_err_pulse", err_pulses - base, 1);
      exp_err++;
`else
      check("missing_last_err_tied", err_pulses - base, 0);
`endif

      // Random data with 30% idle beats over three frames
      base = err_pulses;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < NP; k++) fr[k] = 8'($urandom);
         send_frame(1'b1, 1'b1, NP - 1);
      end
      repeat (4) tick();
      check("random_no_err", err_pulses - base, 0);

      check("queue_empty", exp_q.size(), 0);
      check("frames_seen", popped, pushed);
      check("err_pulse_count", err_pulses, exp_err);
      check("err_pulse_width", err_cycles, err_pulses);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ln_input_deserializer.md
LN_INPUT_DESERIALIZER -- requirements
Module: ln_input_deserializer

Interface
REQ-001 SHALL have parameter N_PIX, default 784, pixels per frame; this is the layer-0 input feature count.
REQ-002 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-003 SHALL have parameter THRESH, default 8'd128, binarization threshold.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  pixel beat valid.
REQ-007 SHALL have port in_ready  output  1  pixel beat accepted when in_valid&&in_ready.
REQ-008 SHALL have port in_data  input  PIX_W  unsigned grayscale pixel.
REQ-009 SHALL have port in_last  input  1  marks the final pixel of a frame.
REQ-010 SHALL have port out_valid  output  1  binarized frame available.
REQ-011 SHALL have port out_ready  input  1  layer-0 neuron array consumes the frame.
REQ-012 SHALL have port out_data  output  N_PIX  binarized frame feeding the layer-0 neuron fan-in selectors.
REQ-013 SHALL have port err_last  output  1  one-cycle framing-error pulse.

Function
REQ-014 SHALL binarize each accepted pixel k as bit = (in_data >= THRESH), unsigned compare, and store it in out_data[k], with k = 0..N_PIX-1 in arrival order.
REQ-015 SHALL implement states FILL (accepting, pix_cnt 0..N_PIX-1) and FULL (holding a frame); pix_cnt width = $clog2(N_PIX).
REQ-016 SHALL drive in_ready = (state==FILL), combinationally from state only; it SHALL NOT depend on in_valid.
REQ-017 SHALL, on an accept in FILL with pix_cnt < N_PIX-1, increment pix_cnt.
REQ-018 SHALL, on an accept with pix_cnt == N_PIX-1, write the bit, clear pix_cnt, and enter FULL; out_valid = 1 from the next cycle.
REQ-019 SHALL hold out_data and out_valid stable in FULL until out_valid&&out_ready.
REQ-020 SHALL, on out_valid&&out_ready, return to FILL with out_valid = 0 next cycle; out_data retains its last value and is overwritten bit by bit.
REQ-021 SHALL NOT bypass a pixel in the cycle a frame is consumed; minimum period per frame is N_PIX+1 cycles.
REQ-022 SHALL ignore in_data and in_last when no accept occurs.

Reset
REQ-023 SHALL, on rst_n low, asynchronously set state=FILL, pix_cnt=0, out_valid=0, out_data=0, err_last=0.
REQ-024 SHALL discard a partial or held frame on reset mid-operation; the first accepted beat after reset is pixel 0.

Configuration
REQ-025 SHALL compile framing checking in when macro LN_LAST_CHECK_EN is defined.
REQ-026 SHALL, with LN_LAST_CHECK_EN defined, treat in_last=1 on an accept with pix_cnt != N_PIX-1 as an early end: pulse err_last for 1 cycle, clear pix_cnt, stay in FILL, and not raise out_valid.
REQ-027 SHALL, with LN_LAST_CHECK_EN defined, treat in_last=0 on the accept at pix_cnt == N_PIX-1 as a missing last: pulse err_last for 1 cycle and still complete the frame normally.
REQ-028 SHALL, without LN_LAST_CHECK_EN, ignore in_last and tie err_last to 0.

Structure
REQ-029 SHALL take N_PIX, PIX_W and DEF_THRESH defaults and the state enum (FILL, FULL) from shared package ln_input_pkg.
REQ-030 SHALL place the comparator in sub-module ln_pix_binarize (PIX_W in, 1 out, purely combinational); counter, FSM and frame register stay in the top.

Verification
REQ-031 SHALL verify: reset, then 784 beats alternating in_data 8'd200/8'd10 with out_ready=1 -> out_valid at the cycle after beat 783; out_data = 784'h...5555 (even bits 1); consumed in 1 cycle.
REQ-032 SHALL verify: full frame, out_ready=0 for 50 cycles -> out_valid held, in_ready=0, out_data unchanged; out_ready=1 -> in_ready=1 the next cycle.
REQ-033 SHALL verify: in_data = 127 and 128 -> bits 0 and 1 respectively (threshold boundary).
REQ-034 SHALL verify: rst_n pulsed low after pixel 400 -> out_valid=0, out_data=0; then 784 fresh beats -> exactly one frame, bit 0 from the first post-reset beat.
REQ-035 SHALL verify, with LN_LAST_CHECK_EN: in_last at pixel 99 -> err_last one pulse, no out_valid; next 784 beats with in_last on 783 -> a clean frame and no err_last.
REQ-036 SHALL verify: random in_valid stalls (30% idle) across 3 frames -> frames bit-exact against a model, err_last never asserted.
